// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and requester id types for the core-memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } mem_arb_state_t;
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } mem_req_id_t;
endpackage

// File: rtl/mem_arbiter_burst_limiter.sv
// mem_arbiter_burst_limiter: DMA-over-CPU priority with a cap on consecutive DMA grants
//   clock, reset     : clock, async active-high reset
//   idle_i           : arbiter is in IDLE and may grant this cycle
//   cpu_req_i        : CPU requesting (rd or wr)
//   dma_req_i        : DMA requesting (rd or wr)
//   grant_o          : a grant happens this cycle
//   owner_dma_o      : winner of this cycle's grant (1 = DMA)
module mem_arbiter_burst_limiter
  import mem_arbiter_pkg::*;
#(
  parameter int DMA_BURST_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic idle_i,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  output logic grant_o,
  output logic owner_dma_o
);
  localparam int CNT_W = $clog2(DMA_BURST_MAX + 2);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(DMA_BURST_MAX);
  logic [CNT_W-1:0] burst_q, burst_d;
  logic cpu_turn;
  always_comb begin
    cpu_turn    = cpu_req_i && (DMA_BURST_MAX != 0) && (burst_q == CAP);
    owner_dma_o = dma_req_i && !cpu_turn;
    grant_o     = idle_i && (cpu_req_i || dma_req_i);
    // counter only tracks DMA grants that made a waiting CPU wait longer
    burst_d = !idle_i      ? burst_q :
              !cpu_req_i   ? '0 :
              !owner_dma_o ? '0 :
              (burst_q == '1) ? burst_q : burst_q + 1'b1;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) burst_q <= '0;
    else       burst_q <= burst_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous SRAM between the CPU controller and the DMA channel
//   clock, reset                          : clock, async active-high reset
//   cpu_rd_en/cpu_wr_en/cpu_addr/cpu_wdata: CPU request, held until cpu_finished
//   cpu_rdata, cpu_finished               : CPU read data, one-cycle completion pulse
//   dma_*                                 : same interface for the data-break channel
//   sram_ce/we/addr/wdata, sram_rdata     : SRAM port, one ce cycle per transaction
//   busy, grant_dma, protocol_err         : status (protocol_err is sticky)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 12,
  parameter int RD_LAT        = 2,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_finished,
  input  logic              dma_rd_en,
  input  logic              dma_wr_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_finished,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              grant_dma,
  output logic              protocol_err
);
  mem_arb_state_t    state_q, state_d;
  mem_req_id_t       owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              perr_q, perr_d;
  logic              grant, owner_dma;

  mem_arbiter_burst_limiter #(.DMA_BURST_MAX(DMA_BURST_MAX)) u_limiter (
    .clock      (clock),
    .reset      (reset),
    .idle_i     (state_q == ARB_IDLE),
    .cpu_req_i  (cpu_rd_en | cpu_wr_en),
    .dma_req_i  (dma_rd_en | dma_wr_en),
    .grant_o    (grant),
    .owner_dma_o(owner_dma)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    perr_d      = perr_q | (cpu_rd_en & cpu_wr_en) | (dma_rd_en & dma_wr_en);
    case (state_q)
      ARB_IDLE: if (grant) begin
        state_d = ARB_ISSUE;
        owner_d = owner_dma ? REQ_DMA : REQ_CPU;
        // wr_en dominates so a conflicting rd+wr request executes as a write
        we_d    = owner_dma ? dma_wr_en : cpu_wr_en;
        addr_d  = owner_dma ? dma_addr  : cpu_addr;
        wdata_d = owner_dma ? dma_wdata : cpu_wdata;
      end
      ARB_ISSUE: begin
        state_d = we_q ? ARB_DONE : ARB_WAIT;
        lat_d   = 3'(RD_LAT);
      end
      ARB_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d     = ARB_DONE;
          cpu_rdata_d = (owner_q == REQ_CPU) ? sram_rdata : cpu_rdata_q;
          dma_rdata_d = (owner_q == REQ_DMA) ? sram_rdata : dma_rdata_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      perr_q      <= perr_d;
    end

  assign sram_ce      = state_q == ARB_ISSUE;
  assign sram_we      = sram_ce & we_q;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign busy         = state_q != ARB_IDLE;
  assign grant_dma    = owner_q == REQ_DMA;
  assign cpu_finished = (state_q == ARB_DONE) && (owner_q == REQ_CPU);
  assign dma_finished = (state_q == ARB_DONE) && (owner_q == REQ_DMA);
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign protocol_err = perr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench over five arbiter configurations
module tb_mem_arbiter;
  localparam int N = 5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic        cpu_rd[N], cpu_wr[N], dma_rd[N], dma_wr[N];
  logic [11:0] cpu_addr[N], cpu_wdata[N], dma_addr[N], dma_wdata[N];
  logic [11:0] cpu_rdata[N], dma_rdata[N], sram_addr[N], sram_wdata[N], sram_rdata[N];
  logic        cpu_fin[N], dma_fin[N], sram_ce[N], sram_we[N], busy[N], grant_dma[N], perr[N];
  logic [11:0] exp_mem[N][4096];
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g < 4) ? g + 1 : 2;
    localparam int BM  = (g < 4) ? 4 : 0;
    logic [11:0] mem [4096];
    logic [11:0] pipe [LAT];
    mem_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LAT(LAT), .DMA_BURST_MAX(BM)) u_dut (
      .clock(clock), .reset(reset),
      .cpu_rd_en(cpu_rd[g]), .cpu_wr_en(cpu_wr[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_rdata(cpu_rdata[g]), .cpu_finished(cpu_fin[g]),
      .dma_rd_en(dma_rd[g]), .dma_wr_en(dma_wr[g]), .dma_addr(dma_addr[g]), .dma_wdata(dma_wdata[g]),
      .dma_rdata(dma_rdata[g]), .dma_finished(dma_fin[g]),
      .sram_ce(sram_ce[g]), .sram_we(sram_we[g]), .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]),
      .sram_rdata(sram_rdata[g]),
      .busy(busy[g]), .grant_dma(grant_dma[g]), .protocol_err(perr[g])
    );
    initial for (int i = 0; i < 4096; i++) mem[i] = '0;
    // SRAM: data for a read issued in cycle c is valid LAT cycles later; noise otherwise
    always @(posedge clock) begin
      if (sram_ce[g] && sram_we[g]) mem[sram_addr[g]] <= sram_wdata[g];
      pipe[0] <= (sram_ce[g] && !sram_we[g]) ? mem[sram_addr[g]] : 12'($urandom);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_rdata[g] = pipe[LAT-1];
  end

  function automatic int lat_of(input int k);
    return (k < 4) ? k + 1 : 2;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs(input int k);
    cpu_rd[k] = 0; cpu_wr[k] = 0; cpu_addr[k] = 0; cpu_wdata[k] = 0;
    dma_rd[k] = 0; dma_wr[k] = 0; dma_addr[k] = 0; dma_wdata[k] = 0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 20 && busy[k]; i++) step();
  endtask

  // Drives one request from an idle arbiter and reports what happened; cycle 0 is the request cycle.
  task automatic do_txn(input int k, input bit dma, input bit rd, input bit wr,
                        input logic [11:0] a, input logic [11:0] d,
                        output int fin, output int ce_n, output int ce_cyc, output bit ce_we,
                        output logic [11:0] ce_addr, output logic [11:0] ce_wdata,
                        output logic [11:0] rdata, output bit other);
    fin = -1; ce_n = 0; ce_cyc = -1; ce_we = 0; ce_addr = 0; ce_wdata = 0; rdata = 0; other = 0;
    wait_idle(k);
    if (dma) begin dma_rd[k] = rd; dma_wr[k] = wr; dma_addr[k] = a; dma_wdata[k] = d; end
    else     begin cpu_rd[k] = rd; cpu_wr[k] = wr; cpu_addr[k] = a; cpu_wdata[k] = d; end
    for (int n = 1; n <= 30; n++) begin
      step();
      if (sram_ce[k]) begin
        ce_n++; ce_cyc = n; ce_we = sram_we[k]; ce_addr = sram_addr[k]; ce_wdata = sram_wdata[k];
      end
      if (dma ? cpu_fin[k] : dma_fin[k]) other = 1;
      if (dma ? dma_fin[k] : cpu_fin[k]) begin
        fin = n;
        rdata = dma ? dma_rdata[k] : cpu_rdata[k];
        break;
      end
    end
    clear_inputs(k);
  endtask

  task automatic test_reset;
    for (int k = 0; k < N; k++) clear_inputs(k);
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 0;
    step();
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({cpu_fin[k], dma_fin[k], sram_ce[k], sram_we[k], busy[k], grant_dma[k], perr[k]} !== 7'b0) begin
        failures++;
        $display("FAIL reset_ctrl[%0d] got=%b exp=0000000", k,
                 {cpu_fin[k], dma_fin[k], sram_ce[k], sram_we[k], busy[k], grant_dma[k], perr[k]});
      end
      checks++;
      if ({cpu_rdata[k], dma_rdata[k], sram_addr[k], sram_wdata[k]} !== 48'b0) begin
        failures++;
        $display("FAIL reset_data[%0d] got=%h exp=0", k, {cpu_rdata[k], dma_rdata[k], sram_addr[k], sram_wdata[k]});
      end
    end
  endtask

  task automatic test_write_read;
    int fin, ce_n, ce_cyc; bit ce_we, other; logic [11:0] ca, cw, rd;
    do_txn(1, 0, 0, 1, 12'o0200, 12'o7777, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other);
    exp_mem[1][12'o0200] = 12'o7777;
    checks++; if (fin !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", fin); end
    checks++; if (ce_n !== 1 || ce_cyc !== 1 || ce_we !== 1) begin
      failures++; $display("FAIL wr_ce got n=%0d cyc=%0d we=%0d exp n=1 cyc=1 we=1", ce_n, ce_cyc, ce_we); end
    checks++; if (ca !== 12'o0200 || cw !== 12'o7777) begin
      failures++; $display("FAIL wr_bus got addr=%o data=%o exp addr=200 data=7777", ca, cw); end
    do_txn(1, 0, 1, 0, 12'o0200, 12'o0000, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other);
    checks++; if (fin !== 4) begin failures++; $display("FAIL rd_latency got=%0d exp=4", fin); end
    checks++; if (rd !== 12'o7777) begin failures++; $display("FAIL rd_data got=%o exp=7777", rd); end
    checks++; if (ce_n !== 1 || ce_we !== 0) begin
      failures++; $display("FAIL rd_ce got n=%0d we=%0d exp n=1 we=0", ce_n, ce_we); end
  endtask

  task automatic test_random(input int k, input int iters);
    int fin, ce_n, ce_cyc, exp_fin; bit ce_we, other, dma, wr; logic [11:0] ca, cw, rd, a, d;
    for (int it = 0; it < iters; it++) begin
      dma = 1'($urandom); wr = 1'($urandom);
      a = 12'($urandom_range(0, 63)); d = 12'($urandom);
      do_txn(k, dma, !wr, wr, a, d, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other);
      exp_fin = wr ? 2 : 2 + lat_of(k);
      checks++; if (fin !== exp_fin) begin
        failures++; $display("FAIL rand_latency[%0d] it=%0d got=%0d exp=%0d", k, it, fin, exp_fin); end
      checks++; if (ce_n !== 1 || ce_cyc !== 1 || ce_we !== wr || ca !== a) begin
        failures++; $display("FAIL rand_ce[%0d] it=%0d got n=%0d cyc=%0d we=%0d addr=%h exp n=1 cyc=1 we=%0d addr=%h",
                             k, it, ce_n, ce_cyc, ce_we, ca, wr, a); end
      checks++; if (other !== 0) begin
        failures++; $display("FAIL rand_other_fin[%0d] it=%0d got=1 exp=0", k, it); end
      if (wr) begin
        checks++; if (cw !== d) begin failures++; $display("FAIL rand_wdata[%0d] got=%h exp=%h", k, cw, d); end
        exp_mem[k][a] = d;
      end else begin
        checks++; if (rd !== exp_mem[k][a]) begin
          failures++; $display("FAIL rand_rdata[%0d] addr=%h got=%h exp=%h", k, a, rd, exp_mem[k][a]); end
      end
    end
  endtask

  task automatic test_both;
    int fin, ce_n, ce_cyc, cd, cc; bit ce_we, other; logic [11:0] ca, cw, rd, prev, cpu_at_dma, dma_got, cpu_got;
    do_txn(1, 0, 0, 1, 12'd10, 12'o1111, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other); exp_mem[1][10] = 12'o1111;
    do_txn(1, 1, 0, 1, 12'd11, 12'o6666, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other); exp_mem[1][11] = 12'o6666;
    do_txn(1, 0, 0, 1, 12'd12, 12'o3333, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other); exp_mem[1][12] = 12'o3333;
    do_txn(1, 0, 1, 0, 12'd12, 12'o0, fin, ce_n, ce_cyc, ce_we, ca, cw, prev, other);
    wait_idle(1);
    cd = -1; cc = -1; cpu_at_dma = 0; dma_got = 0; cpu_got = 0;
    cpu_rd[1] = 1; cpu_addr[1] = 12'd10;
    dma_rd[1] = 1; dma_addr[1] = 12'd11;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (dma_fin[1]) begin cd = n; dma_got = dma_rdata[1]; cpu_at_dma = cpu_rdata[1]; dma_rd[1] = 0; end
      if (cpu_fin[1]) begin cc = n; cpu_got = cpu_rdata[1]; cpu_rd[1] = 0; break; end
    end
    clear_inputs(1);
    checks++; if (cd !== 4) begin failures++; $display("FAIL both_dma_first got=%0d exp=4", cd); end
    checks++; if (cc !== 9) begin failures++; $display("FAIL both_cpu_next got=%0d exp=9", cc); end
    checks++; if (dma_got !== exp_mem[1][11]) begin failures++; $display("FAIL both_dma_data got=%o exp=%o", dma_got, exp_mem[1][11]); end
    checks++; if (cpu_at_dma !== exp_mem[1][12]) begin failures++; $display("FAIL both_cpu_kept got=%o exp=%o", cpu_at_dma, exp_mem[1][12]); end
    checks++; if (cpu_got !== exp_mem[1][10]) begin failures++; $display("FAIL both_cpu_data got=%o exp=%o", cpu_got, exp_mem[1][10]); end
  endtask

  task automatic test_burst;
    int got_own[2][10], got_cyc[2][10], got_gd[2][10], nrec[2];
    int kk[2] = '{1, 4};
    int bm[2] = '{4, 0};
    int eo;
    for (int q = 0; q < 2; q++) begin
      wait_idle(kk[q]);
      nrec[q] = 0;
      for (int j = 0; j < 10; j++) begin got_own[q][j] = -1; got_cyc[q][j] = -1; got_gd[q][j] = -1; end
    end
    for (int q = 0; q < 2; q++) begin
      dma_wr[kk[q]] = 1; dma_addr[kk[q]] = 12'o7000; dma_wdata[kk[q]] = 12'o5555;
      cpu_wr[kk[q]] = 1; cpu_addr[kk[q]] = 12'o7001; cpu_wdata[kk[q]] = 12'o2222;
    end
    for (int n = 1; n <= 80; n++) begin
      step();
      for (int q = 0; q < 2; q++)
        if (nrec[q] < 10 && (dma_fin[kk[q]] || cpu_fin[kk[q]])) begin
          got_own[q][nrec[q]] = dma_fin[kk[q]] ? 1 : 0;
          got_cyc[q][nrec[q]] = n;
          got_gd[q][nrec[q]] = int'(grant_dma[kk[q]]);
          nrec[q]++;
        end
      if (nrec[0] == 10 && nrec[1] == 10) break;
    end
    for (int q = 0; q < 2; q++) clear_inputs(kk[q]);
    repeat (6) step();
    exp_mem[1][12'o7000] = 12'o5555; exp_mem[4][12'o7000] = 12'o5555; exp_mem[1][12'o7001] = 12'o2222;
    for (int q = 0; q < 2; q++)
      for (int j = 0; j < 10; j++) begin
        eo = (bm[q] != 0 && (j % (bm[q] + 1)) == bm[q]) ? 0 : 1;
        checks++; if (got_own[q][j] !== eo || got_gd[q][j] !== eo) begin
          failures++; $display("FAIL burst_owner[%0d] grant=%0d got=%0d gd=%0d exp=%0d", kk[q], j, got_own[q][j], got_gd[q][j], eo); end
        checks++; if (got_cyc[q][j] !== 2 + 3 * j) begin
          failures++; $display("FAIL burst_timing[%0d] grant=%0d got=%0d exp=%0d", kk[q], j, got_cyc[q][j], 2 + 3 * j); end
      end
  endtask

  task automatic test_protocol;
    int fin, ce_n, ce_cyc; bit ce_we, other; logic [11:0] ca, cw, rd;
    checks++; if (perr[1] !== 0) begin failures++; $display("FAIL perr_initial got=%0d exp=0", perr[1]); end
    do_txn(1, 0, 1, 1, 12'd40, 12'o1234, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other);
    exp_mem[1][40] = 12'o1234;
    checks++; if (fin !== 2 || ce_we !== 1 || cw !== 12'o1234) begin
      failures++; $display("FAIL perr_as_write got fin=%0d we=%0d data=%o exp fin=2 we=1 data=1234", fin, ce_we, cw); end
    checks++; if (perr[1] !== 1) begin failures++; $display("FAIL perr_set got=%0d exp=1", perr[1]); end
    do_txn(1, 0, 1, 0, 12'd40, 12'o0, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other);
    checks++; if (rd !== 12'o1234) begin failures++; $display("FAIL perr_readback got=%o exp=1234", rd); end
    checks++; if (perr[1] !== 1 || perr[0] !== 0) begin
      failures++; $display("FAIL perr_sticky got=%0d other=%0d exp=1 other=0", perr[1], perr[0]); end
  endtask

  task automatic test_reset_mid;
    int fin, ce_n, ce_cyc; bit ce_we, other, saw; logic [11:0] ca, cw, rd;
    wait_idle(1);
    cpu_rd[1] = 1; cpu_addr[1] = 12'o0200;
    step(); step();
    checks++; if (busy[1] !== 1 || sram_ce[1] !== 0) begin
      failures++; $display("FAIL mid_in_wait got busy=%0d ce=%0d exp busy=1 ce=0", busy[1], sram_ce[1]); end
    #2 reset = 1;
    clear_inputs(1);
    #1;
    checks++; if ({cpu_fin[1], dma_fin[1], sram_ce[1], sram_we[1], busy[1], grant_dma[1], perr[1]} !== 7'b0) begin
      failures++; $display("FAIL mid_reset_ctrl got=%b exp=0000000",
                           {cpu_fin[1], dma_fin[1], sram_ce[1], sram_we[1], busy[1], grant_dma[1], perr[1]}); end
    checks++; if ({cpu_rdata[1], dma_rdata[1], sram_addr[1], sram_wdata[1]} !== 48'b0) begin
      failures++; $display("FAIL mid_reset_data got=%h exp=0", {cpu_rdata[1], dma_rdata[1], sram_addr[1], sram_wdata[1]}); end
    @(negedge clock) reset = 0;
    saw = 0;
    for (int n = 0; n < 8; n++) begin step(); if (cpu_fin[1]) saw = 1; end
    checks++; if (saw !== 0) begin failures++; $display("FAIL mid_no_finish got=1 exp=0"); end
    do_txn(1, 0, 1, 0, 12'o0200, 12'o0, fin, ce_n, ce_cyc, ce_we, ca, cw, rd, other);
    checks++; if (fin !== 4 || rd !== exp_mem[1][12'o0200]) begin
      failures++; $display("FAIL mid_recover got fin=%0d data=%o exp fin=4 data=%o", fin, rd, exp_mem[1][12'o0200]); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      clear_inputs(k);
      for (int i = 0; i < 4096; i++) exp_mem[k][i] = '0;
    end
    test_reset();
    test_write_read();
    test_random(1, 30);
    for (int k = 0; k < 4; k++) test_random(k, 8);
    test_random(4, 8);
    test_both();
    test_burst();
    test_protocol();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
